// File: rtl/coord_project_seq.sv
// Projects an unsigned 3D point onto the image plane with pinhole intrinsics,
// scales to output units, clamps to the image and mirrors by source quadrant.
module coord_project_seq #(
    parameter int DW    = 16,
    parameter int CW    = 10,
    parameter int IMG_W = 4000,
    parameter int IMG_H = 2900,
    parameter int RATE  = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic [DW-1:0] z,
    input  logic [1:0]    quadrant,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] x_2d,
    output logic [DW-1:0] y_2d,
    output logic          out_err
);
    localparam int NW   = DW + CW + 1;
    localparam int PW   = NW + $clog2(RATE + 1);
    localparam int CNTW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, DIV, POST, HOLD} state_t;

    state_t state, state_nx;

    logic [CW-1:0]   fx, fy, cx, cy;
    logic [CW-1:0]   sfx, sfy, scx, scy;
    logic [DW-1:0]   sx, sy, sz;
    logic [1:0]      sq;
    logic [NW-1:0]   qx, qy;
    logic [DW-1:0]   rx, ry;
    logic [CNTW-1:0] cnt;
    logic            accept;
    logic            z_zero;
    logic [NW-1:0]   nx, ny;
    logic [PW-1:0]   scaled_x, scaled_y;
    logic [DW-1:0]   tx, ty;

    function automatic logic [DW+NW-1:0] div_step(input logic [NW-1:0] n,
                                                  input logic [DW-1:0] r,
                                                  input logic [DW-1:0] d);
        logic [DW:0]   trial;
        logic [DW-1:0] diff;
        trial = {r, n[NW-1]};
        diff  = trial[DW-1:0] - d;
        if (trial >= {1'b0, d})
            return {diff, n[NW-2:0], 1'b1};
        else
            return {trial[DW-1:0], n[NW-2:0], 1'b0};
    endfunction

    assign in_ready = rst_n & (state == IDLE);
    assign accept   = in_valid & in_ready;
    assign z_zero   = (sz == '0);

    assign nx = NW'(sfx) * NW'(sx) + NW'(scx) * NW'(sz);
    assign ny = NW'(sfy) * NW'(sy) + NW'(scy) * NW'(sz);

    assign scaled_x = PW'(qx) * PW'(RATE);
    assign scaled_y = PW'(qy) * PW'(RATE);
    assign tx = (scaled_x > PW'(IMG_W)) ? DW'(IMG_W) : DW'(scaled_x);
    assign ty = (scaled_y > PW'(IMG_H)) ? DW'(IMG_H) : DW'(scaled_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fx <= CW'(185);
            fy <= CW'(185);
            cx <= CW'(105);
            cy <= CW'(77);
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    fx <= cfg_data;
                2'd1:    fy <= cfg_data;
                2'd2:    cx <= cfg_data;
                default: cy <= cfg_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = DIV;
            DIV:  if (cnt == CNTW'(NW)) state_nx = POST;
            POST: state_nx = HOLD;
            HOLD: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // DIV spends its first cycle forming nx/ny from the snapshot, then NW
    // quotient steps; this gives the fixed accept-to-valid latency of NW+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfx <= '0; sfy <= '0; scx <= '0; scy <= '0;
            sx <= '0; sy <= '0; sz <= '0; sq <= '0;
            qx <= '0; qy <= '0; rx <= '0; ry <= '0;
            cnt <= '0;
            x_2d <= '0; y_2d <= '0; out_err <= 1'b0; out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        sx <= x; sy <= y; sz <= z; sq <= quadrant;
                        sfx <= fx; sfy <= fy; scx <= cx; scy <= cy;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) begin
                        qx <= z_zero ? '0 : nx;
                        qy <= z_zero ? '0 : ny;
                        rx <= '0;
                        ry <= '0;
                    end else if (!z_zero) begin
                        {rx, qx} <= div_step(qx, rx, sz);
                        {ry, qy} <= div_step(qy, ry, sz);
                    end
                end
                POST: begin
                    out_valid <= 1'b1;
                    out_err   <= z_zero;
                    if (z_zero) begin
                        x_2d <= '0;
                        y_2d <= '0;
                    end else begin
                        x_2d <= (sq[0] == sq[1]) ? tx : DW'(IMG_W) - tx;
                        y_2d <= sq[1] ? ty : DW'(IMG_H) - ty;
                    end
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coord_project_seq.sv
// Randomized and directed checks of coord_project_seq against an arithmetic
// reference model of the projection, clamp and mirror rules.
module tb_coord_project_seq;
    localparam int DW    = 16;
    localparam int CW    = 10;
    localparam int IMG_W = 4000;
    localparam int IMG_H = 2900;
    localparam int RATE  = 19;
    localparam int NW    = DW + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x, y, z;
    logic [1:0]    quadrant;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] x_2d, y_2d;
    logic          out_err;

    coord_project_seq #(.DW(DW), .CW(CW), .IMG_W(IMG_W), .IMG_H(IMG_H), .RATE(RATE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z), .quadrant(quadrant),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_2d(x_2d), .y_2d(y_2d), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_bad = 0;
    longint coef[4];

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void reset_coefs();
        coef[0] = 185; coef[1] = 185; coef[2] = 105; coef[3] = 77;
    endfunction

    function automatic void model(input longint px, input longint py, input longint pz,
                                  input logic [1:0] q,
                                  output longint ex, output longint ey, output longint eerr);
        longint tx, ty;
        if (pz == 0) begin
            ex = 0; ey = 0; eerr = 1;
        end else begin
            tx = ((coef[0] * px + coef[2] * pz) / pz) * RATE;
            ty = ((coef[1] * py + coef[3] * pz) / pz) * RATE;
            if (tx > IMG_W) tx = IMG_W;
            if (ty > IMG_H) ty = IMG_H;
            ex = (q[0] == q[1]) ? tx : IMG_W - tx;
            ey = q[1] ? ty : IMG_H - ty;
            eerr = 0;
        end
    endfunction

    // Presents one sample (optionally with a concurrent cfg write) and returns
    // half a cycle after the accept edge.
    task automatic send(input longint px, input longint py, input longint pz, input logic [1:0] q,
                        input logic we, input logic [1:0] addr, input longint data);
        int w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (!in_ready) check("ready_timeout", 0, 1);
        x = DW'(px); y = DW'(py); z = DW'(pz); quadrant = q;
        in_valid = 1'b1;
        cfg_we = we; cfg_addr = addr; cfg_data = CW'(data);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b0;
        if (we) coef[addr] = data;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input longint data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = CW'(data);
        @(negedge clk);
        cfg_we = 1'b0;
        coef[addr] = data;
    endtask

    task automatic wait_valid(input string tag);
        int w = 0;
        while (!out_valid && w < NW + 10) begin @(negedge clk); w++; end
        check({tag, "_lat"}, longint'(cyc - acc_cyc), NW + 2);
    endtask

    task automatic collect(input string tag, input longint ex, input longint ey, input longint eerr);
        wait_valid(tag);
        check({tag, "_x"}, x_2d, ex);
        check({tag, "_y"}, y_2d, ey);
        check({tag, "_err"}, out_err, eerr);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        longint ex, ey, ee, rx, ry, rz;
        logic [1:0] rq;
        bit saw_valid;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; x = '0; y = '0; z = '0; quadrant = '0;
        reset_coefs();
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_x", x_2d, 0);
        check("rst_y", y_2d, 0);
        check("rst_err", out_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Reference points with known answers
        send(40, 20, 160, 2'd0, 1'b0, 2'd0, 0); collect("q0", 2869, 1000, 0);
        send(40, 20, 160, 2'd1, 1'b0, 2'd0, 0); collect("q1", 1131, 1000, 0);
        send(40, 20, 160, 2'd2, 1'b0, 2'd0, 0); collect("q2", 1131, 1900, 0);
        send(40, 20, 160, 2'd3, 1'b0, 2'd0, 0); collect("q3", 2869, 1900, 0);
        send(1234, 999, 0, 2'd1, 1'b0, 2'd0, 0); collect("z0", 0, 0, 1);
        send(65535, 65535, 1, 2'd3, 1'b0, 2'd0, 0); collect("clamp_q3", 4000, 2900, 0);
        send(65535, 65535, 1, 2'd0, 1'b0, 2'd0, 0); collect("clamp_q0", 4000, 0, 0);

        // Stall in HOLD with a competing sample presented upstream
        send(40, 20, 160, 2'd0, 1'b0, 2'd0, 0);
        wait_valid("stall");
        x = 16'd100; y = 16'd50; z = 16'd200; quadrant = 2'd2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_x", x_2d, 2869);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
        end
        model(100, 50, 200, 2'd2, ex, ey, ee);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bubble_valid", out_valid, 0);
        check("bubble_in_ready", in_ready, 1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bubble_accepted", in_ready, 0);
        collect("after_stall", ex, ey, ee);

        // Coefficient write while a sample is dividing
        send(40, 20, 160, 2'd0, 1'b0, 2'd0, 0);
        repeat (3) @(negedge clk);
        cfg_write(2'd0, 100);
        collect("cfg_mid_div", 2869, 1000, 0);
        model(40, 20, 160, 2'd3, ex, ey, ee);
        send(40, 20, 160, 2'd3, 1'b0, 2'd0, 0);
        collect("cfg_new_fx", ex, ey, ee);

        // Reset mid-divide discards the sample and restores coefficients
        send(40, 20, 160, 2'd0, 1'b0, 2'd0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_coefs();
        saw_valid = 1'b0;
        for (int i = 0; i < NW + 6; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_rst_no_valid", saw_valid, 0);
        send(40, 20, 160, 2'd0, 1'b0, 2'd0, 0); collect("post_rst", 2869, 1000, 0);

        // Random samples, some with cfg writes at the accept edge or mid-flight
        for (int n = 0; n < 40; n++) begin
            int sel;
            logic we0;
            logic [1:0] a0;
            longint d0;
            sel = $urandom_range(0, 9);
            rx = $urandom_range(0, 65535);
            ry = $urandom_range(0, 65535);
            if (sel == 0)      rz = 0;
            else if (sel < 3)  rz = $urandom_range(1, 4);
            else if (sel < 6)  rz = $urandom_range(1000, 65535);
            else               rz = $urandom_range(1, 65535);
            if (sel > 6) begin rx = rx % 300; ry = ry % 300; end
            rq = 2'($urandom_range(0, 3));
            we0 = 1'($urandom_range(0, 3) == 0);
            a0 = 2'($urandom_range(0, 3));
            d0 = $urandom_range(0, 1023);
            model(rx, ry, rz, rq, ex, ey, ee);
            send(rx, ry, rz, rq, we0, a0, d0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
                cfg_write(2'($urandom_range(0, 3)), $urandom_range(0, 1023));
            end
            collect("rand", ex, ey, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
